freq_counter: RTL and testbench

- Upstream stage of the bricksort sorter: builds the per-symbol frequency table that bricksort consumes through its freq_table_in input.
- Accepts a byte stream through a valid/ready handshake and counts occurrences of each symbol value in a register array.
- On the last symbol it freezes the table and asserts done_out, so the sorter can latch a stable table.

---
 rtl/freq_counter.sv | 103 ++++++++++
 tb/tb_freq_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/freq_counter.sv
// freq_counter: per-symbol frequency table builder feeding the bricksort sorter.
//
// Counts occurrences of each symbol value on a valid/ready byte stream. The
// beat flagged with symbol_last_in is counted, then the table freezes and
// done_out stays high until the next start_in.
//
// Ports:
//   clk_in           system clock, rising edge
//   rst_in           asynchronous active-high reset
//   start_in         pulse: clear the table and open a new message (ignored mid-count)
//   symbol_in        symbol value to count
//   symbol_valid_in  symbol_in valid this cycle
//   symbol_last_in   current valid beat is the final symbol of the message
//   symbol_ready_out block accepts a symbol this cycle (high while counting)
//   freq_table_out   unpacked count array, index = symbol value
//   busy_out         high while counting
//   done_out         high while the table is frozen and stable
//   overflow_out     sticky: some count saturated during the current message
module freq_counter #(
  parameter int TABLE_SIZE   = 256,
  parameter int DATA_WIDTH   = 16,
  parameter int SYMBOL_WIDTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [SYMBOL_WIDTH-1:0] symbol_in,
  input  logic                    symbol_valid_in,
  input  logic                    symbol_last_in,
  output logic                    symbol_ready_out,
  output logic [DATA_WIDTH-1:0]   freq_table_out [TABLE_SIZE],
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    overflow_out
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t state;
  logic   busy_r, done_r, ovf_r;
  logic   accept, clr, hit_max;

  // busy_r is registered alongside state so ready/busy come straight off a flop.
  assign accept  = symbol_valid_in && busy_r;
  // Start only opens a new message from IDLE or DONE; mid-count it is ignored.
  assign clr     = start_in && !busy_r;
  assign hit_max = &freq_table_out[symbol_in];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          state  <= COUNT;
          busy_r <= 1'b1;
          ovf_r  <= 1'b0;
        end
        COUNT: if (symbol_valid_in) begin
          if (hit_max) ovf_r <= 1'b1;
          if (symbol_last_in) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: if (start_in) begin
          state  <= COUNT;
          busy_r <= 1'b1;
          done_r <= 1'b0;
          ovf_r  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // One saturating counter per symbol. Each entry does its own read-modify-write
  // in a single cycle, so back-to-back beats to the same symbol never collide.
  for (genvar g = 0; g < TABLE_SIZE; g++) begin : g_entry
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
        freq_table_out[g] <= '0;
      else if (clr)
        freq_table_out[g] <= '0;
      else if (accept && symbol_in == SYMBOL_WIDTH'(g) && !(&freq_table_out[g]))
        freq_table_out[g] <= freq_table_out[g] + DATA_WIDTH'(1);
    end
  end

  assign symbol_ready_out = busy_r;
  assign busy_out         = busy_r;
  assign done_out         = done_r;
  assign overflow_out     = ovf_r;

endmodule

// File: tb/tb_freq_counter.sv
module tb_freq_counter;

  logic       clk_in = 1'b0;
  logic       rst_in, start_in, valid, last;
  logic [7:0] sym;

  logic        rdy16, busy16, done16, ovf16;
  logic [15:0] tab16 [256];
  logic        rdy4, busy4, done4, ovf4;
  logic [3:0]  tab4 [256];

  freq_counter #(.TABLE_SIZE(256), .DATA_WIDTH(16), .SYMBOL_WIDTH(8)) dut16 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .symbol_in(sym),
    .symbol_valid_in(valid), .symbol_last_in(last), .symbol_ready_out(rdy16),
    .freq_table_out(tab16), .busy_out(busy16), .done_out(done16), .overflow_out(ovf16));

  freq_counter #(.TABLE_SIZE(256), .DATA_WIDTH(4), .SYMBOL_WIDTH(8)) dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .symbol_in(sym),
    .symbol_valid_in(valid), .symbol_last_in(last), .symbol_ready_out(rdy4),
    .freq_table_out(tab4), .busy_out(busy4), .done_out(done4), .overflow_out(ovf4));

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;

  // Reference model: plain counts per symbol plus "in a message" / "finished" flags.
  int m16 [256];
  int m4  [256];
  bit m_busy, m_done, m_ovf16, m_ovf4;

  task automatic model_reset();
    foreach (m16[i]) begin m16[i] = 0; m4[i] = 0; end
    m_busy = 0; m_done = 0; m_ovf16 = 0; m_ovf4 = 0;
  endtask

  task automatic model_edge();
    if (rst_in) model_reset();
    else if (!m_busy && start_in) begin
      foreach (m16[i]) begin m16[i] = 0; m4[i] = 0; end
      m_busy = 1; m_done = 0; m_ovf16 = 0; m_ovf4 = 0;
    end else if (m_busy && valid) begin
      if (m16[sym] == 65535) m_ovf16 = 1; else m16[sym]++;
      if (m4[sym] == 15) m_ovf4 = 1; else m4[sym]++;
      if (last) begin m_busy = 0; m_done = 1; end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int b16, b4;
    chk({tag, " ready16"}, rdy16, m_busy);
    chk({tag, " busy16"}, busy16, m_busy);
    chk({tag, " done16"}, done16, m_done);
    chk({tag, " ovf16"}, ovf16, m_ovf16);
    chk({tag, " ready4"}, rdy4, m_busy);
    chk({tag, " busy4"}, busy4, m_busy);
    chk({tag, " done4"}, done4, m_done);
    chk({tag, " ovf4"}, ovf4, m_ovf4);
    b16 = 0; b4 = 0;
    for (int i = 255; i >= 0; i--) begin
      if (int'(tab16[i]) != m16[i]) b16 = i;
      if (int'(tab4[i]) != m4[i]) b4 = i;
    end
    chk($sformatf("%s tab16[%0d]", tag, b16), tab16[b16], m16[b16]);
    chk($sformatf("%s tab4[%0d]", tag, b4), tab4[b4], m4[b4]);
  endtask

  // Drive one cycle: inputs change at negedge, model follows the rising edge,
  // outputs are then sampled at the next negedge.
  task automatic cyc(input bit s, input bit v, input bit l, input logic [7:0] y);
    start_in = s; valid = v; last = l; sym = y;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  typedef struct {
    bit s, v, l;
    logic [7:0] y;
    bit e_busy, e_done;
    int e_cnt;
  } vec_t;

  vec_t vt [6];

  initial begin
    rst_in = 1; start_in = 0; valid = 0; last = 0; sym = 0;
    model_reset();

    // Reset and idle
    repeat (2) @(negedge clk_in);
    check_all("reset");
    rst_in = 0;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 8'h00);
    check_all("idle");
    cyc(0, 1, 1, 8'h41);
    chk("idle beat ignored", tab16[8'h41], 0);
    check_all("idle beat");

    // Table-driven short message
    vt[0] = '{1, 0, 0, 8'h41, 1, 0, 0};
    vt[1] = '{0, 1, 0, 8'h41, 1, 0, 1};
    vt[2] = '{0, 1, 0, 8'h42, 1, 0, 1};
    vt[3] = '{0, 1, 0, 8'h41, 1, 0, 2};
    vt[4] = '{0, 1, 1, 8'h41, 0, 1, 3};
    vt[5] = '{0, 1, 0, 8'h42, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      cyc(vt[i].s, vt[i].v, vt[i].l, vt[i].y);
      chk($sformatf("vec%0d busy", i), busy16, vt[i].e_busy);
      chk($sformatf("vec%0d done", i), done16, vt[i].e_done);
      chk($sformatf("vec%0d entry", i), tab16[vt[i].y], vt[i].e_cnt);
      check_all($sformatf("vec%0d", i));
    end

    // 300 accepted beats of 0xFF, valid low every third cycle; last held high
    // on idle cycles before the final beat must be ignored
    begin
      int acc = 0, n = 0;
      bit v;
      cyc(1, 0, 0, 8'h00);
      while (acc < 300) begin
        v = (n % 3) != 2;
        cyc(0, v, acc == 299, 8'hFF);
        if (v) acc++;
        n++;
      end
    end
    chk("burst tab16[FF]", tab16[8'hFF], 300);
    chk("burst done16", done16, 1);
    chk("burst ovf16", ovf16, 0);
    chk("burst tab4[FF]", tab4[8'hFF], 15);
    chk("burst ovf4", ovf4, 1);
    check_all("burst");

    // Saturation on the narrow counter, then cleared by the next start
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) cyc(0, 1, i == 19, 8'h00);
    chk("sat tab4[0]", tab4[0], 15);
    chk("sat ovf4", ovf4, 1);
    chk("sat tab16[0]", tab16[0], 20);
    check_all("sat");
    cyc(1, 0, 0, 8'h00);
    chk("sat clr tab4[0]", tab4[0], 0);
    chk("sat clr ovf4", ovf4, 0);
    check_all("sat clr");
    cyc(0, 1, 1, 8'h00);

    // Back-to-back messages: done low for exactly the one counting cycle
    chk("b2b done before", done16, 1);
    cyc(1, 0, 0, 8'h00);
    chk("b2b done gap", done16, 0);
    cyc(0, 1, 1, 8'h10);
    chk("b2b done after", done16, 1);
    chk("b2b tab16[10]", tab16[8'h10], 1);
    check_all("b2b");

    // Randomized messages, including stray starts mid-count
    for (int i = 0; i < 800; i++) begin
      bit s, v, l;
      s = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 24) == 0);
      cyc(s, v, l, 8'($urandom_range(0, 7)));
      check_all("rand");
    end

    // Async reset mid-count, between clock edges
    if (m_busy) cyc(0, 1, 1, 8'h00);
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h20 + i));
    check_all("pre-rst");
    #2 rst_in = 1;
    model_reset();
    #1;
    check_all("async rst");
    @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 8'h05);
      chk("rst hold done", done16, 0);
      check_all("rst hold");
    end
    rst_in = 0;
    cyc(0, 1, 1, 8'h05);
    chk("post rst done", done16, 0);
    check_all("post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
